// File: rtl/alu_pkg.sv
// Shared ALU control codes, funct encodings and MDU state type for alu_dec_md.
// ALU_DEC_DIV_EN controls whether div/divu count as multiply/divide functs.
package alu_pkg;

    typedef logic [3:0] alu_ctrl_t;

    localparam alu_ctrl_t ALU_AND  = 4'b0000;
    localparam alu_ctrl_t ALU_OR   = 4'b0001;
    localparam alu_ctrl_t ALU_ADD  = 4'b0010;
    localparam alu_ctrl_t ALU_XOR  = 4'b0011;
    localparam alu_ctrl_t ALU_NOR  = 4'b0100;
    localparam alu_ctrl_t ALU_SUB  = 4'b0110;
    localparam alu_ctrl_t ALU_SLT  = 4'b0111;
    localparam alu_ctrl_t ALU_SLTU = 4'b1000;
    localparam alu_ctrl_t ALU_SLL  = 4'b1001;
    localparam alu_ctrl_t ALU_SRL  = 4'b1010;
    localparam alu_ctrl_t ALU_SRA  = 4'b1011;
    localparam alu_ctrl_t ALU_NONE = 4'b1111;

    typedef logic [5:0] funct_t;

    localparam funct_t F_ADD   = 6'b100000;
    localparam funct_t F_ADDU  = 6'b100001;
    localparam funct_t F_SUB   = 6'b100010;
    localparam funct_t F_SUBU  = 6'b100011;
    localparam funct_t F_AND   = 6'b100100;
    localparam funct_t F_OR    = 6'b100101;
    localparam funct_t F_XOR   = 6'b100110;
    localparam funct_t F_NOR   = 6'b100111;
    localparam funct_t F_SLT   = 6'b101010;
    localparam funct_t F_SLTU  = 6'b101011;
    localparam funct_t F_SLL   = 6'b000000;
    localparam funct_t F_SRL   = 6'b000010;
    localparam funct_t F_SRA   = 6'b000011;
    localparam funct_t F_MULT  = 6'b011000;
    localparam funct_t F_MULTU = 6'b011001;
    localparam funct_t F_DIV   = 6'b011010;
    localparam funct_t F_DIVU  = 6'b011011;
    localparam funct_t F_MFHI  = 6'b010000;
    localparam funct_t F_MTHI  = 6'b010001;
    localparam funct_t F_MFLO  = 6'b010010;
    localparam funct_t F_MTLO  = 6'b010011;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_FUNCT = 2'b10;
    localparam logic [1:0] OP_SLT   = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2
    } md_state_t;

    function automatic logic is_md_funct(input funct_t f);
        logic r;
        r = 1'b0;
        case (f)
            F_MULT, F_MULTU, F_MFHI, F_MTHI, F_MFLO, F_MTLO: r = 1'b1;
`ifdef ALU_DEC_DIV_EN
            F_DIV, F_DIVU: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/md_iter.sv
// Iterative multiply/divide datapath: one shift-add or restoring step per cycle on magnitudes.
// Divider datapath only present when ALU_DEC_DIV_EN is defined.
module md_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             run,
    input  logic             md_div,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   m, acc_hi, acc_lo, mag_a, mag_b, nxt_hi, nxt_lo;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod;
    logic               neg_q;

    assign mag_a = (sgn && a[WIDTH-1]) ? -a : a;
    assign mag_b = (sgn && b[WIDTH-1]) ? -b : b;
    assign done  = run && (count == CW'(WIDTH - 1));

    // acc_lo starts as the multiplier and is shifted out as product bits shift in
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m} : '0);
    assign prod    = {mul_sum, acc_lo[WIDTH-1:1]};

`ifdef ALU_DEC_DIV_EN
    logic             is_div, neg_r, b_zero, q_bit;
    logic [WIDTH-1:0] a_orig;
    logic [WIDTH:0]   rem_sh, diff;

    assign rem_sh = {acc_hi, acc_lo[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, m};
    assign q_bit  = !diff[WIDTH];

    always_comb begin
        {nxt_hi, nxt_lo} = prod;
        if (is_div) begin
            nxt_hi = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], q_bit};
        end
    end

    always_comb begin
        {hi, lo} = neg_q ? -prod : prod;
        if (is_div) begin
            if (b_zero) begin
                hi = a_orig;
                lo = '1;
            end else begin
                hi = neg_r ? -nxt_hi : nxt_hi;
                lo = neg_q ? -nxt_lo : nxt_lo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            is_div <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            a_orig <= '0;
        end else if (start) begin
            is_div <= md_div;
            neg_r  <= sgn && a[WIDTH-1];
            b_zero <= (b == '0);
            a_orig <= a;
        end
    end
`else
    logic unused_md_div;

    assign unused_md_div    = md_div;
    assign {nxt_hi, nxt_lo} = prod;
    assign {hi, lo}         = neg_q ? -prod : prod;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= '0;
            m      <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            neg_q  <= 1'b0;
        end else if (start) begin
            count  <= '0;
            acc_hi <= '0;
            neg_q  <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef ALU_DEC_DIV_EN
            m      <= md_div ? mag_b : mag_a;
            acc_lo <= md_div ? mag_a : mag_b;
`else
            m      <= mag_a;
            acc_lo <= mag_b;
`endif
        end else if (run) begin
            count  <= done ? '0 : count + 1'b1;
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
        end
    end

endmodule

// File: rtl/alu_dec_md.sv
// ALU control decoder with a sequential multiply/divide unit, HI/LO and stall handshake.
// Define ALU_DEC_DIV_EN to include divide support; otherwise div/divu decode as illegal.
//
// state   | meaning
// MD_IDLE | MDU free, MD instructions issue on the next edge
// MD_MUL  | shift-add multiply iterating, HI/LO written on final edge
// MD_DIV  | restoring divide iterating, HI/LO written on final edge
module alu_dec_md
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic [CTRL_W-1:0] alu_control,
    output logic              illegal,
    output logic              md_busy,
    output logic              stall,
    output logic [WIDTH-1:0]  md_result,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo
);

    md_state_t        state_q, state_d;
    alu_ctrl_t        ctrl;
    logic             is_md, md_req, md_issue, start_mul, start_div, iter_done;
    logic [WIDTH-1:0] iter_hi, iter_lo;

    assign is_md     = is_md_funct(funct);
    assign md_req    = instr_valid && (alu_op == OP_FUNCT) && is_md;
    assign md_busy   = (state_q != MD_IDLE);
    assign stall     = md_req && md_busy;
    assign md_issue  = md_req && !md_busy;
    assign start_mul = md_issue && (funct == F_MULT || funct == F_MULTU);
`ifdef ALU_DEC_DIV_EN
    assign start_div = md_issue && (funct == F_DIV || funct == F_DIVU);
`else
    assign start_div = 1'b0;
`endif

    always_comb begin
        ctrl    = ALU_NONE;
        illegal = 1'b0;
        case (alu_op)
            OP_ADD: ctrl = ALU_ADD;
            OP_SUB: ctrl = ALU_SUB;
            OP_SLT: ctrl = ALU_SLT;
            default: begin
                case (funct)
                    F_ADD, F_ADDU: ctrl = ALU_ADD;
                    F_SUB, F_SUBU: ctrl = ALU_SUB;
                    F_AND:         ctrl = ALU_AND;
                    F_OR:          ctrl = ALU_OR;
                    F_XOR:         ctrl = ALU_XOR;
                    F_NOR:         ctrl = ALU_NOR;
                    F_SLT:         ctrl = ALU_SLT;
                    F_SLTU:        ctrl = ALU_SLTU;
                    F_SLL:         ctrl = ALU_SLL;
                    F_SRL:         ctrl = ALU_SRL;
                    F_SRA:         ctrl = ALU_SRA;
                    default:       illegal = !is_md;
                endcase
            end
        endcase
        alu_control = CTRL_W'(ctrl);
    end

    always_comb begin
        md_result = '0;
        if (alu_op == OP_FUNCT && funct == F_MFHI) md_result = hi;
        else if (alu_op == OP_FUNCT && funct == F_MFLO) md_result = lo;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: begin
                if (start_mul) state_d = MD_MUL;
                else if (start_div) state_d = MD_DIV;
            end
            MD_MUL, MD_DIV: if (iter_done) state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= MD_IDLE;
        else state_q <= state_d;
    end

    // Completion and mthi/mtlo cannot coincide: moves only issue while idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (iter_done) begin
            hi <= iter_hi;
            lo <= iter_lo;
        end else if (md_issue && funct == F_MTHI) begin
            hi <= a;
        end else if (md_issue && funct == F_MTLO) begin
            lo <= a;
        end
    end

    md_iter #(.WIDTH(WIDTH)) u_md_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_mul || start_div),
        .run    (md_busy),
        .md_div (start_div),
        .sgn    (!funct[0]),
        .a      (a),
        .b      (b),
        .done   (iter_done),
        .hi     (iter_hi),
        .lo     (iter_lo)
    );

endmodule

// File: tb/tb_alu_dec_md.sv
// Self-checking bench for alu_dec_md: decode table, MDU results/latency, stall, reset abort.
// Divide cases follow ALU_DEC_DIV_EN: real results when defined, illegal decode otherwise.
module tb_alu_dec_md;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         instr_valid = 1'b0;
    logic [1:0]   alu_op = 2'b00;
    logic [5:0]   funct = 6'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   alu_control;
    logic         illegal, md_busy, stall;
    logic [W-1:0] md_result, hi, lo;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    always #5 clk = ~clk;

    alu_dec_md #(.WIDTH(W), .CTRL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .alu_op(alu_op),
        .funct(funct), .a(a), .b(b), .alu_control(alu_control), .illegal(illegal),
        .md_busy(md_busy), .stall(stall), .md_result(md_result), .hi(hi), .lo(lo)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic void model_dec(input logic [1:0] op, input logic [5:0] f,
                                      output logic [3:0] c, output logic ill);
        c = 4'b1111;
        ill = 1'b0;
        if (op == 2'b00) c = 4'b0010;
        else if (op == 2'b01) c = 4'b0110;
        else if (op == 2'b11) c = 4'b0111;
        else begin
            case (f)
                6'b100000, 6'b100001: c = 4'b0010;
                6'b100010, 6'b100011: c = 4'b0110;
                6'b100100: c = 4'b0000;
                6'b100101: c = 4'b0001;
                6'b100110: c = 4'b0011;
                6'b100111: c = 4'b0100;
                6'b101010: c = 4'b0111;
                6'b101011: c = 4'b1000;
                6'b000000: c = 4'b1001;
                6'b000010: c = 4'b1010;
                6'b000011: c = 4'b1011;
                6'b011000, 6'b011001, 6'b010000, 6'b010001, 6'b010010, 6'b010011: c = 4'b1111;
`ifdef ALU_DEC_DIV_EN
                6'b011010, 6'b011011: c = 4'b1111;
`endif
                default: ill = 1'b1;
            endcase
        end
    endfunction

    // Reference results from plain 64-bit arithmetic on sign- or zero-extended operands
    function automatic void model_md(input logic [5:0] f, input logic [31:0] x, y,
                                     output logic [31:0] h, output logic [31:0] l);
        logic signed [63:0] sx, sy, p, q, r;
        if (f[0] == 1'b0) begin
            sx = {{32{x[31]}}, x};
            sy = {{32{y[31]}}, y};
        end else begin
            sx = {32'b0, x};
            sy = {32'b0, y};
        end
        h = '0;
        l = '0;
        if (f == F_MULT || f == F_MULTU) begin
            p = sx * sy;
            h = p[63:32];
            l = p[31:0];
        end else if (y == 32'b0) begin
            h = x;
            l = 32'hFFFF_FFFF;
        end else begin
            q = sx / sy;
            r = sx % sy;
            h = r[31:0];
            l = q[31:0];
        end
    endfunction

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    task automatic run_md(input logic [5:0] f, input logic [31:0] x, y, output int busy_n);
        @(negedge clk);
        instr_valid = 1'b1; alu_op = 2'b10; funct = f; a = x; b = y;
        @(negedge clk);
        instr_valid = 1'b0; funct = F_ADD;
        busy_n = 0;
        while (md_busy && busy_n < 100) begin
            busy_n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        instr_valid = 1'b1; alu_op = 2'b10; funct = F_MULT; a = 32'd3; b = 32'd5;
        repeat (3) @(negedge clk);
        checks++;
        if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", md_busy); end
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        checks++;
        if (hi !== '0 || lo !== '0) begin errors++; $display("FAIL reset_hilo: got %h/%h expected 0/0", hi, lo); end
        instr_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_no_issue: busy %b expected 0", md_busy); end
    endtask

    task automatic test_decode_directed();
        @(negedge clk);
        alu_op = 2'b10; funct = 6'b100111; #1;
        checks++;
        if (alu_control !== 4'b0100 || illegal !== 1'b0) begin errors++; $display("FAIL dec_nor: got %b/%b expected 0100/0", alu_control, illegal); end
        funct = 6'b111111; #1;
        checks++;
        if (alu_control !== 4'b1111 || illegal !== 1'b1) begin errors++; $display("FAIL dec_unknown: got %b/%b expected 1111/1", alu_control, illegal); end
        alu_op = 2'b01; #1;
        checks++;
        if (alu_control !== 4'b0110 || illegal !== 1'b0) begin errors++; $display("FAIL dec_sub_op: got %b/%b expected 0110/0", alu_control, illegal); end
    endtask

    task automatic test_decode_random();
        logic [5:0] known [21] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                   6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h18, 6'h19, 6'h1A,
                                   6'h1B, 6'h10, 6'h11, 6'h12, 6'h13};
        logic [3:0] ec;
        logic ei;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            alu_op = 2'($urandom_range(0, 3));
            if (i % 4 != 0) alu_op = 2'b10;
            if ($urandom_range(0, 2) != 0) funct = known[$urandom_range(0, 20)];
            else funct = 6'($urandom);
            #1;
            model_dec(alu_op, funct, ec, ei);
            checks++;
            if (alu_control !== ec || illegal !== ei) begin
                errors++;
                $display("FAIL dec_rand op=%b funct=%b: got %b/%b expected %b/%b", alu_op, funct, alu_control, illegal, ec, ei);
            end
        end
    endtask

    task automatic test_mult();
        int n;
        model_md(F_MULT, 32'hFFFF_FFFD, 32'd7, exp_hi, exp_lo);
        run_md(F_MULT, 32'hFFFF_FFFD, 32'd7, n);
        checks++;
        if (n !== 32) begin errors++; $display("FAIL mult_busy_cycles: got %0d expected 32", n); end
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_neg: got %h/%h expected ffffffff/ffffffeb", hi, lo); end
    endtask

    task automatic test_div();
`ifdef ALU_DEC_DIV_EN
        logic [5:0]  fs [5] = '{F_DIVU, F_DIV, F_DIV, F_DIV, F_DIVU};
        logic [31:0] xs [5] = '{32'd100, 32'hFFFF_FFF9, 32'd5, 32'h8000_0000, 32'hFFFF_FFF9};
        logic [31:0] ys [5] = '{32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] rh [5] = '{32'd2, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'hFFFF_FFF9};
        logic [31:0] rl [5] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        int n;
        for (int i = 0; i < 5; i++) begin
            run_md(fs[i], xs[i], ys[i], n);
            exp_hi = rh[i];
            exp_lo = rl[i];
            checks++;
            if (n !== 32 || hi !== rh[i] || lo !== rl[i]) begin
                errors++;
                $display("FAIL div_case%0d: got busy=%0d hi=%h lo=%h expected busy=32 hi=%h lo=%h", i, n, hi, lo, rh[i], rl[i]);
            end
        end
`else
        logic [5:0] fs [2] = '{F_DIV, F_DIVU};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            instr_valid = 1'b1; alu_op = 2'b10; funct = fs[i]; a = 32'd100; b = 32'd7;
            #1;
            checks++;
            if (illegal !== 1'b1 || alu_control !== 4'b1111 || stall !== 1'b0) begin
                errors++;
                $display("FAIL div_disabled_dec%0d: got ill=%b ctrl=%b stall=%b expected 1/1111/0", i, illegal, alu_control, stall);
            end
            @(negedge clk);
            instr_valid = 1'b0;
            checks++;
            if (md_busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
                errors++;
                $display("FAIL div_disabled_noissue%0d: got busy=%b hi=%h lo=%h expected 0/%h/%h", i, md_busy, hi, lo, exp_hi, exp_lo);
            end
        end
`endif
    endtask

    task automatic test_random_md();
        logic [5:0] f;
        logic [31:0] x, y, eh, el;
        int n;
        for (int i = 0; i < 10; i++) begin
`ifdef ALU_DEC_DIV_EN
            f = (i % 2 == 0) ? 6'(F_MULT + 6'($urandom_range(0, 1))) : 6'(F_DIV + 6'($urandom_range(0, 1)));
`else
            f = 6'(F_MULT + 6'($urandom_range(0, 1)));
`endif
            x = pick_op();
            y = pick_op();
            model_md(f, x, y, eh, el);
            run_md(f, x, y, n);
            exp_hi = eh;
            exp_lo = el;
            checks++;
            if (n !== 32 || hi !== eh || lo !== el) begin
                errors++;
                $display("FAIL md_rand f=%b a=%h b=%h: got busy=%0d hi=%h lo=%h expected busy=32 hi=%h lo=%h", f, x, y, n, hi, lo, eh, el);
            end
        end
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] x, y;
        int n;
        x = $urandom | 32'h1;
        y = $urandom | 32'h100;
        run_md(F_MTHI, x, 32'd0, n);
        run_md(F_MTLO, y, 32'd0, n);
        exp_hi = x;
        exp_lo = y;
        checks++;
        if (n !== 0 || hi !== x || lo !== y) begin errors++; $display("FAIL mthi_mtlo: got busy=%0d hi=%h lo=%h expected 0/%h/%h", n, hi, lo, x, y); end
        alu_op = 2'b10; funct = F_MFHI; #1;
        checks++;
        if (md_result !== x) begin errors++; $display("FAIL mfhi_read: got %h expected %h", md_result, x); end
        funct = F_MFLO; #1;
        checks++;
        if (md_result !== y) begin errors++; $display("FAIL mflo_read: got %h expected %h", md_result, y); end
        funct = F_XOR; #1;
        checks++;
        if (md_result !== '0) begin errors++; $display("FAIL md_result_other: got %h expected 0", md_result); end
    endtask

    task automatic test_mid_reset();
        int n;
        logic [31:0] eh, el;
        @(negedge clk);
        instr_valid = 1'b1; alu_op = 2'b10; funct = F_MULTU; a = 32'h1234_5678; b = 32'h9ABC_DEF1;
        @(negedge clk);
        instr_valid = 1'b0; funct = F_ADD;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        exp_hi = '0;
        exp_lo = '0;
        checks++;
        if (md_busy !== 1'b0 || hi !== '0 || lo !== '0) begin errors++; $display("FAIL mid_reset: got busy=%b hi=%h lo=%h expected 0/0/0", md_busy, hi, lo); end
        rst_n = 1'b1;
        model_md(F_MULT, 32'hFFFF_8000, 32'h0001_2345, eh, el);
        run_md(F_MULT, 32'hFFFF_8000, 32'h0001_2345, n);
        exp_hi = eh;
        exp_lo = el;
        checks++;
        if (n !== 32 || hi !== eh || lo !== el) begin errors++; $display("FAIL after_reset_mult: got busy=%0d hi=%h lo=%h expected 32/%h/%h", n, hi, lo, eh, el); end
    endtask

    task automatic test_stall();
        int n;
        logic [31:0] eh, el;
        model_md(F_MULTU, 32'hDEAD_BEEF, 32'h0BAD_F00D, eh, el);
        @(negedge clk);
        instr_valid = 1'b1; alu_op = 2'b10; funct = F_MULTU; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
        @(negedge clk);
        funct = F_ADD; #1;
        checks++;
        if (stall !== 1'b0 || md_busy !== 1'b1 || alu_control !== 4'b0010) begin
            errors++;
            $display("FAIL add_during_busy: got stall=%b busy=%b ctrl=%b expected 0/1/0010", stall, md_busy, alu_control);
        end
        @(negedge clk);
        funct = F_MFLO; #1;
        n = 0;
        while (stall && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        exp_hi = eh;
        exp_lo = el;
        checks++;
        if (n !== 31) begin errors++; $display("FAIL mflo_stall_cycles: got %0d expected 31", n); end
        checks++;
        if (md_result !== el) begin errors++; $display("FAIL mflo_after_stall: got %h expected %h", md_result, el); end
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n;
        logic [31:0] h1, l1, h2, l2;
        model_md(F_MULT, 32'h7FFF_FFFF, 32'h8000_0000, h1, l1);
        model_md(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, h2, l2);
        @(negedge clk);
        instr_valid = 1'b1; alu_op = 2'b10; funct = F_MULT; a = 32'h7FFF_FFFF; b = 32'h8000_0000;
        @(negedge clk);
        funct = F_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        n = 0;
        while (stall && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 32 || hi !== h1 || lo !== l1) begin errors++; $display("FAIL b2b_first: got stall=%0d hi=%h lo=%h expected 32/%h/%h", n, hi, lo, h1, l1); end
        @(negedge clk);
        instr_valid = 1'b0; funct = F_ADD;
        n = 0;
        while (md_busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        exp_hi = h2;
        exp_lo = l2;
        checks++;
        if (n !== 32 || hi !== h2 || lo !== l2) begin errors++; $display("FAIL b2b_second: got busy=%0d hi=%h lo=%h expected 32/%h/%h", n, hi, lo, h2, l2); end
    endtask

    initial begin
        test_reset();
        test_decode_directed();
        test_decode_random();
        test_mult();
        test_div();
        test_random_md();
        test_mthi_mtlo();
        test_mid_reset();
        test_stall();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_dec_md.md
# alu_dec_md

Parametrised successor to the single-cycle ALU decoder. Combinationally decodes `alu_op`/`funct` into a widened ALU control code covering the full R-type ALU set. Adds a sequential multiply/divide unit (MDU) with HI/LO registers, a busy/stall handshake toward the datapath, and an illegal-instruction flag. Sits between the main decoder and the ALU/register-file write-back mux.

## Interface
- `WIDTH`, 32: datapath width for operands, HI and LO.
- `CTRL_W`, 4: `alu_control` width. Must be ≥4.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `instr_valid` in 1: the current instruction is real, not a bubble.
- `alu_op` in 2: from the main decoder.
- `funct` in 6: instruction bits [5:0].
- `a`, `b` in WIDTH: rs and rt operand values.
- `alu_control` out CTRL_W: ALU operation code.
- `illegal` out 1: unknown funct while `alu_op=10`.
- `md_busy` out 1: MDU iteration in progress.
- `stall` out 1: datapath must hold PC and the instruction.
- `md_result` out WIDTH: write-back value for mfhi/mflo.
- `hi`, `lo` out WIDTH: architectural HI/LO registers.

## Operation
- **alu_op decode:** 00→add 0010; 01→sub 0110; 11→slt 0111 (slti); 10→decode by funct.
- **Legacy codes are unchanged, zero-extended:**
  - and 0000, or 0001, add 0010, sub 0110, slt 0111.
- **New ALU codes:**
  - xor 0011, nor 0100, sltu 1000.
  - sll 1001, srl 1010, sra 1011.
- **Funct map:**
  - 100000 add, 100001 addu→add, 100010 sub, 100011 subu→sub.
  - 100100 and, 100101 or, 100110 xor, 100111 nor.
  - 101010 slt, 101011 sltu.
  - 000000 sll, 000010 srl, 000011 sra.
- **MD functs:**
  - 011000 mult, 011001 multu, 011010 div, 011011 divu.
  - 010000 mfhi, 010010 mflo, 010001 mthi, 010011 mtlo.
  - All MD functs drive `alu_control=1111` (no ALU op). `illegal=0`.
- **Unknown funct:** `alu_control=1111`, `illegal=1`. Never X.
- **MDU FSM states:** IDLE, MUL, DIV. `md_busy = (state != IDLE)`.
- **IDLE transitions:**
  - Issue occurs on a `clk` edge with `instr_valid`, `alu_op=10`, an MD funct, and `!md_busy`.
  - mult/multu→MUL; div/divu→DIV.
  - Operands latched, counter cleared.
- **mthi/mtlo:** write `a` into HI/LO at the issue edge. No state change.
- **Signed ops:** operate on magnitudes. Final sign fix-up on write.
  - Product/quotient negative iff sign(a)^sign(b).
  - Remainder takes sign(a).
- **MUL:** shift-add, one bit per cycle, WIDTH iterations. Final edge writes HI=product[2W-1:W], LO=product[W-1:0].
- **DIV:** restoring, WIDTH iterations. Final edge writes LO=quotient, HI=remainder.
  - Divide by zero: LO=all-ones, HI=a (unsigned and signed alike).
  - Signed MIN/−1: LO=MIN, HI=0. This falls out of the magnitude path.
- **md_result:** HI for mfhi, LO for mflo, else 0.
- **Stall:** `stall = md_busy & instr_valid & alu_op==10 & funct∈MD set`. Stalled MD instructions are not issued and re-present next cycle. Non-MD instructions never stall.

## Timing
- Decode outputs and `md_result` are combinational, zero latency.
- **Reset (rst_n=0 at an edge):**
  - state=IDLE, counter=0, HI=LO=0.
  - `md_busy=0`, `stall=0`.
  - Applies mid-iteration too: the operation is aborted and no HI/LO write occurs.
- **Issue at edge t0:**
  - `md_busy=1` during cycles t0..t0+WIDTH−1.
  - HI/LO update at edge t0+WIDTH.
  - `md_busy=0` in the following cycle.
- mfhi presented during busy stalls until the cycle after HI/LO update, then reads the new value the same cycle.
- Back-to-back MD ops: the second issues on the edge where `md_busy` is already 0.

## Configuration
- `ALU_DEC_DIV_EN` defined: DIV state and divider datapath present.
- `ALU_DEC_DIV_EN` undefined: divider logic removed.
  - div/divu decode as illegal (`illegal=1`, `alu_control=1111`).
  - No issue, no stall.
  - mult/mfhi/mflo/mthi/mtlo unaffected.

## Structure
- Shared package `alu_pkg` holds:
  - `alu_ctrl_t` code constants (ALU_AND…ALU_NONE=1111).
  - Funct constants (F_ADD…F_MTLO).
  - MDU state enum.
- Decoder and FSM live in the top module.
- One sub-module `md_iter`: the iterative multiply/divide datapath with counter. Inputs start/mode/signed/operands; outputs done/hi/lo.

## Test plan
- alu_op=10, funct=100111 → `alu_control=0100`. funct=111111 → `alu_control=1111`, `illegal=1`. alu_op=01 → `0110`.
- mult a=0xFFFFFFFD, b=7 → `md_busy` high exactly 32 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- divu a=100, b=7 → LO=14, HI=2. div a=−7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div a=5, b=0 → LO=0xFFFFFFFF, HI=5. div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- mult issued, mflo presented next cycle → `stall=1` for 31 cycles; unstalled cycle shows `md_result`=new LO. An add during busy → `stall=0`.
- rst_n low at iteration 10 → next cycle `md_busy=0`, HI=LO=0. A new mult then completes correctly.
